// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FF_NONE       = 2'd0,
    FF_MISALIGNED = 2'd1,
    FF_RANGE      = 2'd2
  } fetch_fault_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    fetch_fault_t    fault;
  } fetch_entry_t;

  // last_word is the highest legal word address, widened by one bit so the compare cannot wrap
  function automatic fetch_fault_t classify_fault(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN:0]   last_word);
    fetch_fault_t f;
    if (pc[1:0] != 2'b00) begin
      f = FF_MISALIGNED;
    end else if ({1'b0, pc} > last_word) begin
      f = FF_RANGE;
    end else begin
      f = FF_NONE;
    end
    return f;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM port plus decode-side valid/ready handshake of the fetch stage.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [XLEN-1:0] o_rom_addr;
  logic [XLEN-1:0] i_rom_rdata;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_inst;
  fetch_fault_t    o_fault;

  modport master (
    output o_rom_addr,
    input  i_rom_rdata,
    input  i_redirect,
    input  i_redirect_pc,
    output o_valid,
    input  i_ready,
    output o_pc,
    output o_inst,
    output o_fault
  );

  modport slave (
    input  o_rom_addr,
    output i_rom_rdata,
    output i_redirect,
    output i_redirect_pc,
    input  o_valid,
    output i_ready,
    input  o_pc,
    input  o_inst,
    input  o_fault
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetch entries with flush; head reads as zero when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // Qualify push/pop; flush discards both
  always_comb begin
    do_pop_s  = pop & ~empty & ~flush;
    do_push_s = push & ~flush & (~full | do_pop_s);
  end

  // Read/write pointers, wrapping by natural overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_entry;
    end
  end

  // Head view, forced to zero so an empty queue presents a clean bus
  always_comb begin
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, classifies fetch faults and queues
// {pc, inst, fault} entries for decode; redirects flush the queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              MEM_SIZE    = 4096,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [XLEN:0] LAST_WORD = (XLEN+1)'(MEM_SIZE) - 33'd4;

  fetch_state_t    state_r;
  fetch_state_t    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  fetch_fault_t    fault_s;
  fetch_entry_t    entry_s;
  fetch_entry_t    head_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;

  // Build the entry for the current PC; faulting fetches never expose ROM data
  always_comb begin
    fault_s       = classify_fault(pc_r, LAST_WORD);
    entry_s.pc    = pc_r;
    entry_s.fault = fault_s;
    if (fault_s == FF_NONE) begin
      entry_s.inst = bus.i_rom_rdata;
    end else begin
      entry_s.inst = INST_NOP;
    end
  end

  assign pop_s = ~empty_s & bus.i_ready;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a faulting push halts, any redirect resumes
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.i_redirect) begin
          state_next_s = ST_RUN;
        end else if (push_s && (fault_s != FF_NONE)) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (bus.i_redirect) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // FSM outputs: push qualification and next PC, redirect first
  always_comb begin
    push_s    = (state_r == ST_RUN) & ~bus.i_redirect & (~full_s | pop_s);
    pc_next_s = pc_r;
    if (bus.i_redirect) begin
      pc_next_s = bus.i_redirect_pc;
    end else if (push_s && (fault_s == FF_NONE)) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Program counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .flush    (bus.i_redirect),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (entry_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  assign bus.o_rom_addr = pc_r;
  assign bus.o_valid    = ~empty_s;
  assign bus.o_pc       = head_s.pc;
  assign bus.o_inst     = head_s.inst;
  assign bus.o_fault    = head_s.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/redirect traffic checked against a queue-based reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int MEM   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_SIZE    (MEM),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  bit           m_halt;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ROM: valid data only for aligned in-range words, X elsewhere
  assign bus.i_rom_rdata = ((bus.o_rom_addr[1:0] == 2'b00) && (bus.o_rom_addr <= 32'd4092))
                           ? rom_word(bus.o_rom_addr) : 32'hxxxx_xxxx;

  function automatic fetch_fault_t ref_fault(input logic [31:0] a);
    if ((a % 32'd4) != 32'd0) return FF_MISALIGNED;
    if (({32'd0, a} + 64'd4) > 64'(MEM)) return FF_RANGE;
    return FF_NONE;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  // One clock of the architectural rules, applied to the model
  task automatic model_step();
    int           sz;
    bit           pop;
    fetch_entry_t e;
    if (bus.i_redirect) begin
      exp_q.delete();
      m_pc   = bus.i_redirect_pc;
      m_halt = 1'b0;
    end else begin
      sz  = exp_q.size();
      pop = (sz > 0) && bus.i_ready;
      if (pop) void'(exp_q.pop_front());
      if (!m_halt && ((sz < DEPTH) || pop)) begin
        e.pc    = m_pc;
        e.fault = ref_fault(m_pc);
        e.inst  = (e.fault == FF_NONE) ? rom_word(m_pc) : INST_NOP;
        exp_q.push_back(e);
        if (e.fault != FF_NONE) m_halt = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_ready       = 1'b0;
    #12;
    total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.o_valid); else pass_cnt++;
    total_cnt++; if (bus.o_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.o_pc); else pass_cnt++;
    total_cnt++; if (bus.o_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", bus.o_inst); else pass_cnt++;
    total_cnt++; if (bus.o_fault !== FF_NONE) $display("FAIL reset_fault: got %0d want 0", bus.o_fault); else pass_cnt++;
    total_cnt++; if (bus.o_rom_addr !== 32'h0) $display("FAIL reset_rom_addr: got %h want 0", bus.o_rom_addr); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    bus.i_ready = 1'b1;
    cycle();
    total_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL stream_valid0: got %0b want 1", bus.o_valid); else pass_cnt++;
    total_cnt++; if (bus.o_pc !== 32'h0) $display("FAIL stream_pc0: got %h want 0", bus.o_pc); else pass_cnt++;
    total_cnt++; if (bus.o_inst !== 32'h0050_0093) $display("FAIL stream_inst0: got %h want 00500093", bus.o_inst); else pass_cnt++;
    total_cnt++; if (bus.o_rom_addr !== 32'h4) $display("FAIL stream_addr4: got %h want 4", bus.o_rom_addr); else pass_cnt++;
    cycle();
    total_cnt++; if (bus.o_pc !== 32'h4) $display("FAIL stream_pc4: got %h want 4", bus.o_pc); else pass_cnt++;
    total_cnt++; if (bus.o_inst !== 32'h00A0_0113) $display("FAIL stream_inst4: got %h want 00a00113", bus.o_inst); else pass_cnt++;
    total_cnt++; if (bus.o_rom_addr !== 32'h8) $display("FAIL stream_addr8: got %h want 8", bus.o_rom_addr); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [3];
    seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8;
    do_reset();
    bus.i_ready = 1'b0;
    repeat (5) begin
      cycle();
      total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== 32'h0)) $display("FAIL bp_hold: got valid=%0b pc=%h want 1/0", bus.o_valid, bus.o_pc); else pass_cnt++;
    end
    total_cnt++; if (bus.o_rom_addr !== 32'h8) $display("FAIL bp_addr_freeze: got %h want 8", bus.o_rom_addr); else pass_cnt++;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== seq[k])) $display("FAIL bp_drain%0d: got valid=%0b pc=%h want 1/%h", k, bus.o_valid, bus.o_pc, seq[k]); else pass_cnt++;
      cycle();
    end
  endtask

  task automatic test_redirect();
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h40;
    cycle();
    bus.i_redirect = 1'b0;
    total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL redir_bubble: got %0b want 0", bus.o_valid); else pass_cnt++;
    total_cnt++; if (bus.o_rom_addr !== 32'h40) $display("FAIL redir_addr: got %h want 40", bus.o_rom_addr); else pass_cnt++;
    cycle();
    total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== 32'h40)) $display("FAIL redir_pc: got valid=%0b pc=%h want 1/40", bus.o_valid, bus.o_pc); else pass_cnt++;
    total_cnt++; if (bus.o_inst !== rom_word(32'h40)) $display("FAIL redir_inst: got %h want %h", bus.o_inst, rom_word(32'h40)); else pass_cnt++;
    cycle();
    total_cnt++; if (bus.o_pc !== 32'h44) $display("FAIL redir_next: got %h want 44", bus.o_pc); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h42;
    cycle();
    bus.i_redirect = 1'b0;
    cycle();
    total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== 32'h42)) $display("FAIL mis_pc: got valid=%0b pc=%h want 1/42", bus.o_valid, bus.o_pc); else pass_cnt++;
    total_cnt++; if (bus.o_fault !== FF_MISALIGNED) $display("FAIL mis_fault: got %0d want %0d", bus.o_fault, FF_MISALIGNED); else pass_cnt++;
    total_cnt++; if (bus.o_inst !== INST_NOP) $display("FAIL mis_inst: got %h want 00000013", bus.o_inst); else pass_cnt++;
    cycle();
    repeat (3) begin
      total_cnt++; if ((bus.o_valid !== 1'b0) || (bus.o_rom_addr !== 32'h42)) $display("FAIL mis_halt: got valid=%0b addr=%h want 0/42", bus.o_valid, bus.o_rom_addr); else pass_cnt++;
      cycle();
    end
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0;
    cycle();
    bus.i_redirect = 1'b0;
    cycle();
    total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== 32'h0) || (bus.o_inst !== 32'h0050_0093)) $display("FAIL mis_resume: got valid=%0b pc=%h inst=%h want 1/0/00500093", bus.o_valid, bus.o_pc, bus.o_inst); else pass_cnt++;
  endtask

  task automatic test_range();
    logic [31:0]  epc;
    fetch_fault_t ef;
    logic [31:0]  ei;
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFF0;
    cycle();
    bus.i_redirect = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      epc = 32'hFF0 + 32'(4 * k);
      ef  = (k == 4) ? FF_RANGE : FF_NONE;
      ei  = (k == 4) ? 32'h0000_0013 : rom_word(epc);
      total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== epc) || (bus.o_fault !== ef) || (bus.o_inst !== ei))
        $display("FAIL range_k%0d: got v=%0b pc=%h f=%0d i=%h want 1/%h/%0d/%h", k, bus.o_valid, bus.o_pc, bus.o_fault, bus.o_inst, epc, ef, ei);
      else pass_cnt++;
      cycle();
    end
    total_cnt++; if ((bus.o_valid !== 1'b0) || (bus.o_rom_addr !== 32'h1000)) $display("FAIL range_halt: got valid=%0b addr=%h want 0/1000", bus.o_valid, bus.o_rom_addr); else pass_cnt++;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    bus.i_redirect = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bus.i_ready    = ($urandom_range(0, 9) < 7);
      bus.i_redirect = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      case (r)
        6:       bus.i_redirect_pc = 32'hFF8;
        7:       bus.i_redirect_pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b10};
        8:       bus.i_redirect_pc = $urandom;
        9:       bus.i_redirect_pc = 32'hFFFF_FFFC;
        default: bus.i_redirect_pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      cycle();
      total_cnt++; if (bus.o_valid !== (exp_q.size() != 0)) $display("FAIL rand_valid@%0d: got %0b want %0b", n, bus.o_valid, exp_q.size() != 0); else pass_cnt++;
      total_cnt++; if (bus.o_rom_addr !== m_pc) $display("FAIL rand_addr@%0d: got %h want %h", n, bus.o_rom_addr, m_pc); else pass_cnt++;
      if (exp_q.size() != 0) begin
        total_cnt++; if ((bus.o_pc !== exp_q[0].pc) || (bus.o_inst !== exp_q[0].inst) || (bus.o_fault !== exp_q[0].fault))
          $display("FAIL rand_head@%0d: got pc=%h i=%h f=%0d want %h/%h/%0d", n, bus.o_pc, bus.o_inst, bus.o_fault, exp_q[0].pc, exp_q[0].inst, exp_q[0].fault);
        else pass_cnt++;
      end
    end
    bus.i_redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_ready = 1'b0;
    repeat (3) cycle();
    total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_rom_addr !== 32'h8)) $display("FAIL arst_pre: got valid=%0b addr=%h want 1/8", bus.o_valid, bus.o_rom_addr); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL arst_valid: got %0b want 0", bus.o_valid); else pass_cnt++;
    total_cnt++; if (bus.o_rom_addr !== 32'h0) $display("FAIL arst_addr: got %h want 0", bus.o_rom_addr); else pass_cnt++;
    model_reset();
    #1;
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    cycle();
    total_cnt++; if ((bus.o_valid !== 1'b1) || (bus.o_pc !== 32'h0) || (bus.o_inst !== 32'h0050_0093)) $display("FAIL arst_restart: got valid=%0b pc=%h inst=%h want 1/0/00500093", bus.o_valid, bus.o_pc, bus.o_inst); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_range();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
